// File: rtl/sdram_pio_pkg.sv
// Shared types and constants for the SDRAM-to-HPS PIO word fetcher.
package sdram_pio_pkg;

    localparam int unsigned DATA_W          = 16;
    localparam int unsigned DEF_ADDR_STRIDE = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_DATA,
        ST_PRESENT,
        ST_DONE
    } state_e;

endpackage

// File: rtl/sdram_pio_word_fetcher_toggle_sync_edge.sv
// Two-flop synchroniser for an asynchronous toggle, plus edge detect
// producing a one-cycle event per toggle.
module toggle_sync_edge (
    input  logic clk,
    input  logic reset_n,
    input  logic tog_in,
    output logic evt
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = tog_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign evt = sync2_q ^ prev_q;

endmodule

// File: rtl/sdram_pio_word_fetcher.sv
// Fetches consecutive 16-bit SDRAM words over Avalon-MM and presents each
// one on data_out, paced by a req/ack toggle handshake with the HPS.
module sdram_pio_word_fetcher
    import sdram_pio_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned ADDR_STRIDE = DEF_ADDR_STRIDE
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    input  logic              req_toggle,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic [DATA_W-1:0] data_out,
    output logic              ack_toggle,
    output logic              busy,
    output logic              done
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  remaining_q, remaining_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              read_q, read_d;
    logic              req_evt;

    toggle_sync_edge u_req_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .tog_in  (req_toggle),
        .evt     (req_evt)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        data_d      = data_q;
        ack_d       = ack_q;
        done_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        addr_d      = base_addr;
                        remaining_d = word_count;
                        state_d     = ST_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                if (read_q && !avm_waitrequest) begin
                    addr_d  = addr_q + ADDR_W'(ADDR_STRIDE);
                    state_d = ST_WAIT_DATA;
                end
            end
            ST_WAIT_DATA: begin
                if (avm_readdatavalid) begin
                    data_d      = avm_readdata;
                    ack_d       = ~ack_q;
                    remaining_d = remaining_q - CNT_W'(1);
                    state_d     = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (req_evt) begin
                    state_d = (remaining_q != '0) ? ST_ISSUE : ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of where the FSM is heading.
        read_d = (state_d == ST_ISSUE);
        busy_d = (state_d == ST_ISSUE) || (state_d == ST_WAIT_DATA) ||
                 (state_d == ST_PRESENT);
        if (state_d == ST_DONE) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            data_q      <= '0;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            read_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            data_q      <= data_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            read_q      <= read_d;
        end
    end

    assign avm_address = addr_q;
    assign avm_read    = read_q;
    assign data_out    = data_q;
    assign ack_toggle  = ack_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sdram_pio_word_fetcher.sv
// Randomised scoreboard bench for sdram_pio_word_fetcher: an Avalon slave
// model, an HPS-side consumer and a monitor checking against queued expectations.
module tb_sdram_pio_word_fetcher;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] word_count = '0;
    logic        req_toggle = 1'b0;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [15:0] avm_readdata = '0;
    logic        avm_readdatavalid = 1'b0;
    logic [15:0] data_out;
    logic        ack_toggle;
    logic        busy;
    logic        done;

    sdram_pio_word_fetcher #(
        .ADDR_W      (32),
        .CNT_W       (16),
        .ADDR_STRIDE (2)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .base_addr         (base_addr),
        .word_count        (word_count),
        .req_toggle        (req_toggle),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .data_out          (data_out),
        .ack_toggle        (ack_toggle),
        .busy              (busy),
        .done              (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: what the transfer must look like on the bus.
    logic [31:0] exp_addr_q[$];
    logic [15:0] exp_data_q[$];
    logic [15:0] slave_data_q[$];
    int          stalls_q[$];
    int          done_exp = 0;
    int          done_seen = 0;
    int          acc_idx = 0;
    int          consumes = 0;
    int          acks_seen = 0;
    int          rd_total = 0;

    // Slave knobs
    int          stall_left = 0;
    bit          rand_wr = 1'b1;
    int          fixed_lat = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Avalon slave: one pending read, returns queued data after 1..3 cycles.
    initial begin
        bit          acc;
        bit          pending;
        int          lat;
        logic [15:0] pdata;
        pending = 1'b0;
        lat     = 0;
        pdata   = '0;
        forever begin
            @(negedge clk);
            acc = avm_read && !avm_waitrequest;
            if (avm_read && avm_waitrequest && stall_left > 0) stall_left--;
            @(posedge clk);
            #1;
            avm_readdatavalid = 1'b0;
            if (acc) begin
                pending = 1'b1;
                pdata   = (slave_data_q.size() != 0) ? slave_data_q.pop_front() : 16'hDEAD;
                lat     = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
            end
            if (pending) begin
                if (lat == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = pdata;
                    pending           = 1'b0;
                end else begin
                    lat--;
                end
            end
            avm_waitrequest = (stall_left > 0) ? 1'b1 :
                              (rand_wr ? ($urandom_range(0, 3) == 0) : 1'b0);
        end
    end

    // Monitor: pops and compares whenever the DUT presents a read, a word or done.
    initial begin
        logic prev_ack;
        logic prev_rdv;
        int   stall_run;
        bit   outstanding;
        prev_ack    = 1'b0;
        prev_rdv    = 1'b0;
        stall_run   = 0;
        outstanding = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_ack    = ack_toggle;
                prev_rdv    = 1'b0;
                stall_run   = 0;
                outstanding = 1'b0;
                continue;
            end
            if (avm_read) begin
                chk("rd_expected", 32'(exp_addr_q.size() != 0), 32'd1);
                if (exp_addr_q.size() != 0) chk("rd_addr", avm_address, exp_addr_q[0]);
                if (avm_waitrequest) begin
                    stall_run++;
                end else begin
                    chk("rd_gate", 32'(acc_idx), 32'(consumes));
                    chk("one_outstanding", 32'(outstanding), 32'd0);
                    if (exp_addr_q.size() != 0) void'(exp_addr_q.pop_front());
                    stalls_q.push_back(stall_run);
                    stall_run   = 0;
                    acc_idx++;
                    rd_total++;
                    outstanding = 1'b1;
                end
            end
            if (ack_toggle !== prev_ack) begin
                chk("ack_after_rdv", 32'(prev_rdv), 32'd1);
                chk("ack_expected", 32'(exp_data_q.size() != 0), 32'd1);
                if (exp_data_q.size() != 0) chk("data_out", 32'(data_out), 32'(exp_data_q.pop_front()));
                acks_seen++;
                outstanding = 1'b0;
            end
            if (done) begin
                chk("done_expected", 32'(done_exp), 32'd1);
                done_exp = 0;
                done_seen++;
            end
            prev_ack = ack_toggle;
            prev_rdv = avm_readdatavalid;
        end
    end

    task automatic pulse_start(input logic [31:0] b, input logic [15:0] n);
        base_addr  = b;
        word_count = n;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic transfer(input logic [31:0] base, input int cnt, input bit early,
                            input int stall, input bit busy_start, input bit fixed_data);
        logic [15:0] wd[$];
        logic [15:0] d;
        int          ds0, acks0, r0, s0, w;
        logic        ack0;
        bit          early_pending;
        acc_idx    = 0;
        consumes   = 0;
        stall_left = stall;
        rand_wr    = (stall == 0) && !early;
        fixed_lat  = early ? 8 : -1;
        for (int i = 0; i < cnt; i++) begin
            d = fixed_data ? 16'(16'hA001 + i) : 16'($urandom);
            wd.push_back(d);
            exp_addr_q.push_back(base + 32'(2 * i));
            exp_data_q.push_back(d);
            slave_data_q.push_back(d);
        end
        ds0   = done_seen;
        acks0 = acks_seen;
        r0    = rd_total;
        s0    = stalls_q.size();
        ack0  = ack_toggle;
        early_pending = 1'b0;
        if (cnt == 0) done_exp = 1;
        pulse_start(base, 16'(cnt));
        if (cnt == 0) begin
            for (int k = 0; k < 4; k++) begin
                chk("zero_busy", 32'(busy), 32'd0);
                tick();
            end
            chk("zero_done_once", 32'(done_seen - ds0), 32'd1);
            chk("zero_ack_unchanged", 32'(ack_toggle), 32'(ack0));
            chk("zero_no_read", 32'(rd_total - r0), 32'd0);
            return;
        end
        chk("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < cnt; i++) begin
            w = 0;
            while (acks_seen - acks0 < i + 1 && w < 300) begin
                tick();
                w++;
            end
            chk("ack_wait", 32'(acks_seen - acks0), 32'(i + 1));
            if (early_pending) begin
                repeat (10) tick();
                chk("early_no_read", 32'(acc_idx), 32'(i + 1));
                chk("early_data_held", 32'(data_out), 32'(wd[i]));
                early_pending = 1'b0;
            end
            chk("busy_in_present", 32'(busy), 32'd1);
            if (busy_start && i == 0) pulse_start(base ^ 32'h0000_0100, 16'(cnt + 2));
            repeat ($urandom_range(0, 3)) tick();
            if (i == cnt - 1) done_exp = 1;
            consumes++;
            req_toggle = ~req_toggle;
            if (early && i == 0 && cnt > 1) begin
                w = 0;
                while (acc_idx < 2 && w < 100) begin
                    tick();
                    w++;
                end
                chk("early_accept_wait", 32'(acc_idx), 32'd2);
                req_toggle    = ~req_toggle;
                early_pending = 1'b1;
            end
        end
        w = 0;
        while (done_seen == ds0 && w < 20) begin
            tick();
            w++;
        end
        chk("done_seen", 32'(done_seen - ds0), 32'd1);
        chk("done_latency_ok", 32'(w <= 5), 32'd1);
        tick();
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("reads_total", 32'(rd_total - r0), 32'(cnt));
        if (stall > 0) chk("stall_cycles", 32'(stalls_q[s0]), 32'(stall));
        fixed_lat = -1;
        rand_wr   = 1'b1;
    endtask

    initial begin
        int w;
        #3;
        chk("rst_avm_read", 32'(avm_read), 32'd0);
        chk("rst_avm_address", avm_address, 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        chk("rst_ack", 32'(ack_toggle), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (2) tick();

        transfer(32'h0000_1000, 3, 1'b0, 0, 1'b0, 1'b1);
        transfer(32'h0000_2000, 2, 1'b0, 5, 1'b0, 1'b0);
        transfer(32'h0000_4000, 3, 1'b1, 0, 1'b0, 1'b0);
        transfer(32'h0000_5000, 0, 1'b0, 0, 1'b0, 1'b0);
        transfer(32'hFFFF_FFFE, 2, 1'b0, 0, 1'b0, 1'b0);
        transfer(32'h0000_3000, 3, 1'b0, 0, 1'b1, 1'b0);
        for (int t = 0; t < 6; t++) begin
            transfer({$urandom} & 32'hFFFF_FFFE, int'($urandom_range(0, 4)), 1'b0, 0, 1'b0, 1'b0);
        end

        // Abort during WAIT_DATA; the late 0xBEEF must never reach data_out.
        acc_idx   = 0;
        consumes  = 0;
        fixed_lat = 8;
        rand_wr   = 1'b0;
        exp_addr_q.push_back(32'h0000_6000);
        slave_data_q.push_back(16'hBEEF);
        pulse_start(32'h0000_6000, 16'd3);
        w = 0;
        while (acc_idx < 1 && w < 50) begin
            tick();
            w++;
        end
        chk("rst_test_accept", 32'(acc_idx), 32'd1);
        repeat (2) tick();
        reset_n = 1'b0;
        exp_addr_q.delete();
        exp_data_q.delete();
        done_exp = 0;
        #2;
        chk("abort_data_out", 32'(data_out), 32'd0);
        chk("abort_ack", 32'(ack_toggle), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_read", 32'(avm_read), 32'd0);
        tick();
        reset_n = 1'b1;
        repeat (12) tick();
        chk("post_abort_data_out", 32'(data_out), 32'd0);
        chk("post_abort_ack", 32'(ack_toggle), 32'd0);
        chk("post_abort_busy", 32'(busy), 32'd0);
        chk("post_abort_read", 32'(avm_read), 32'd0);
        chk("post_abort_done", 32'(done), 32'd0);
        fixed_lat = -1;
        rand_wr   = 1'b1;

        transfer(32'h0000_7000, 2, 1'b0, 0, 1'b0, 1'b0);
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
